// File: rtl/rr_input_requester.sv
// Input-port requester for a round-robin matrix arbiter: buffers flits, decodes the head
// flit destination, requests the owning output and forwards granted flits under credit control.
module rr_input_requester #(
  parameter int FLIT_W  = 34,
  parameter int N_OUT   = 2,
  parameter int SEL_W   = 1,
  parameter int DEPTH   = 4,
  parameter int CREDITS = 4,
  parameter int CRED_W  = 3
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              in_valid,
  input  logic [FLIT_W-1:0] in_flit,
  output logic              in_ready,
  output logic [N_OUT-1:0]  request_vector,
  input  logic [N_OUT-1:0]  grant_vector,
  output logic              out_valid,
  output logic [FLIT_W-1:0] out_flit,
  output logic [N_OUT-1:0]  out_port,
  input  logic [N_OUT-1:0]  credit_in,
  output logic              err_drop
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACTIVE = 1'b1;

  logic [FLIT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;

  logic [0:0]        state;
  logic [SEL_W-1:0]  dest_q;
  logic [CRED_W-1:0] credit [N_OUT];

  logic [FLIT_W-1:0] head_flit;
  logic [1:0]        head_type;
  logic [SEL_W-1:0]  head_dest;
  logic              fifo_empty;
  logic              fifo_full;
  logic              push;
  logic              pop;
  logic              drop;
  logic              send;
  logic              req_active;
  logic              dest_ok;
  logic [N_OUT-1:0]  dest_onehot;
  logic [N_OUT-1:0]  send_onehot;

  assign head_flit  = mem[rd_ptr];
  assign head_type  = head_flit[FLIT_W-1:FLIT_W-2];
  assign head_dest  = head_flit[SEL_W-1:0];
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CNT_W'(DEPTH));
  assign in_ready   = RST && !fifo_full;
  assign push       = in_valid && in_ready;

  // A destination index is legal only if it names one of the existing output arbiters.
  always_comb begin
    dest_ok = 1'b0;
    for (int i = 0; i < N_OUT; i++) begin
      if (head_dest == SEL_W'(i)) dest_ok = 1'b1;
    end
  end

  // Request is held only while a flit is waiting and the locked output has a free slot.
  always_comb begin
    dest_onehot    = N_OUT'(1) << dest_q;
    req_active     = (state == ACTIVE) && !fifo_empty && (credit[dest_q] != '0);
    request_vector = req_active ? dest_onehot : '0;
    send           = req_active && grant_vector[dest_q];
    send_onehot    = send ? dest_onehot : '0;
    drop           = (state == IDLE) && !fifo_empty && !(head_type[0] && dest_ok);
    pop            = send || drop;
  end

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= in_flit;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // The packet stays locked to dest_q until its tail (or single) flit has been sent.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= IDLE;
      dest_q   <= '0;
      err_drop <= 1'b0;
    end else begin
      if (drop) err_drop <= 1'b1;
      case (state)
        IDLE: begin
          if (!fifo_empty && head_type[0] && dest_ok) begin
            dest_q <= head_dest;
            state  <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (send && head_type[1]) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      out_valid <= 1'b0;
      out_flit  <= '0;
      out_port  <= '0;
    end else begin
      out_valid <= send;
      if (send) begin
        out_flit <= head_flit;
        out_port <= dest_onehot;
      end
    end
  end

  // A return and a send on the same output cancel; returns saturate at the buffer size.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < N_OUT; i++) credit[i] <= CRED_W'(CREDITS);
    end else begin
      for (int i = 0; i < N_OUT; i++) begin
        if (credit_in[i] && !send_onehot[i]) begin
          if (credit[i] != CRED_W'(CREDITS)) credit[i] <= credit[i] + CRED_W'(1);
        end else if (!credit_in[i] && send_onehot[i]) begin
          credit[i] <= credit[i] - CRED_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_rr_input_requester.sv
// Directed bench for rr_input_requester: a vector table for the basic single-flit and
// stalled-grant packets, plus hand sequences for credits, FIFO full, drops and reset.
module tb_rr_input_requester;

  localparam int FLIT_W = 34;

  logic              CLK;
  logic              RST;
  logic              in_valid;
  logic [FLIT_W-1:0] in_flit;
  logic              in_ready;
  logic [1:0]        request_vector;
  logic [1:0]        grant_vector;
  logic              out_valid;
  logic [FLIT_W-1:0] out_flit;
  logic [1:0]        out_port;
  logic [1:0]        credit_in;
  logic              err_drop;

  int compared = 0;
  int mismatched = 0;

  typedef struct {
    logic              vi;
    logic [FLIT_W-1:0] flit;
    logic [1:0]        gnt;
    logic [1:0]        cin;
    logic              e_rdy;
    logic [1:0]        e_req;
    logic              e_ov;
    logic [1:0]        e_port;
    logic [FLIT_W-1:0] e_flit;
  } vec_t;

  vec_t vecs[14];

  logic [FLIT_W-1:0] pkt[8];
  int                pkt_len;
  int                pkt_idx;
  logic [FLIT_W-1:0] last_flit;
  int                ov_cnt;

  localparam logic [FLIT_W-1:0] F1  = 34'h3_1234_5679;
  localparam logic [FLIT_W-1:0] H0  = 34'h1_AAAA_0000;
  localparam logic [FLIT_W-1:0] B0  = 34'h0_BBBB_0002;
  localparam logic [FLIT_W-1:0] T0  = 34'h2_CCCC_0004;
  localparam logic [FLIT_W-1:0] H1  = 34'h1_DDDD_0001;
  localparam logic [FLIT_W-1:0] S0  = 34'h3_EEEE_0006;
  localparam logic [FLIT_W-1:0] X0  = 34'h0_5555_0008;

  rr_input_requester dut (
    .CLK            (CLK),
    .RST            (RST),
    .in_valid       (in_valid),
    .in_flit        (in_flit),
    .in_ready       (in_ready),
    .request_vector (request_vector),
    .grant_vector   (grant_vector),
    .out_valid      (out_valid),
    .out_flit       (out_flit),
    .out_port       (out_port),
    .credit_in      (credit_in),
    .err_drop       (err_drop)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic applyStimulus(input vec_t v);
    in_valid     = v.vi;
    in_flit      = v.flit;
    grant_vector = v.gnt;
    credit_in    = v.cin;
  endtask

  task automatic doReset();
    RST          = 1'b0;
    in_valid     = 1'b0;
    in_flit      = '0;
    grant_vector = '0;
    credit_in    = '0;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b1;
  endtask

  // Drives pkt[] upstream as fast as in_ready allows and counts flits leaving downstream.
  task automatic runCycles(input int n, output int cnt);
    logic accepted;
    cnt = 0;
    for (int c = 0; c < n; c++) begin
      in_valid = (pkt_idx < pkt_len);
      in_flit  = in_valid ? pkt[pkt_idx] : '0;
      #1;
      if (out_valid) begin
        cnt++;
        last_flit = out_flit;
      end
      accepted = in_valid && in_ready;
      tick();
      credit_in = '0;
      if (accepted) pkt_idx++;
    end
    in_valid = 1'b0;
    in_flit  = '0;
  endtask

  initial begin
    // single flit to output 1, then a 3-flit packet to output 0 with grant held off 2 cycles
    vecs[0]  = '{1'b1, F1, 2'b10, 2'b00, 1'b1, 2'b00, 1'b0, 2'b00, '0};
    vecs[1]  = '{1'b0, '0, 2'b10, 2'b00, 1'b1, 2'b00, 1'b0, 2'b00, '0};
    vecs[2]  = '{1'b0, '0, 2'b10, 2'b00, 1'b1, 2'b10, 1'b0, 2'b00, '0};
    vecs[3]  = '{1'b0, '0, 2'b10, 2'b00, 1'b1, 2'b00, 1'b1, 2'b10, F1};
    vecs[4]  = '{1'b0, '0, 2'b00, 2'b00, 1'b1, 2'b00, 1'b0, 2'b00, '0};
    vecs[5]  = '{1'b1, H0, 2'b00, 2'b00, 1'b1, 2'b00, 1'b0, 2'b00, '0};
    vecs[6]  = '{1'b1, B0, 2'b00, 2'b00, 1'b1, 2'b00, 1'b0, 2'b00, '0};
    vecs[7]  = '{1'b1, T0, 2'b00, 2'b00, 1'b1, 2'b01, 1'b0, 2'b00, '0};
    vecs[8]  = '{1'b0, '0, 2'b00, 2'b00, 1'b1, 2'b01, 1'b0, 2'b00, '0};
    vecs[9]  = '{1'b0, '0, 2'b01, 2'b00, 1'b1, 2'b01, 1'b0, 2'b00, '0};
    vecs[10] = '{1'b0, '0, 2'b01, 2'b00, 1'b1, 2'b01, 1'b1, 2'b01, H0};
    vecs[11] = '{1'b0, '0, 2'b01, 2'b00, 1'b1, 2'b01, 1'b1, 2'b01, B0};
    vecs[12] = '{1'b0, '0, 2'b00, 2'b00, 1'b1, 2'b00, 1'b1, 2'b01, T0};
    vecs[13] = '{1'b0, '0, 2'b00, 2'b00, 1'b1, 2'b00, 1'b0, 2'b00, '0};

    pkt_len   = 0;
    pkt_idx   = 0;
    last_flit = '0;

    RST          = 1'b0;
    in_valid     = 1'b0;
    in_flit      = '0;
    grant_vector = '0;
    credit_in    = '0;
    #2;
    checkOutput("reset_in_ready", 64'(in_ready), 64'd0);
    checkOutput("reset_request", 64'(request_vector), 64'd0);
    checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset_out_flit", 64'(out_flit), 64'd0);
    checkOutput("reset_err_drop", 64'(err_drop), 64'd0);
    doReset();

    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("v%0d_in_ready", i), 64'(in_ready), 64'(vecs[i].e_rdy));
      checkOutput($sformatf("v%0d_request", i), 64'(request_vector), 64'(vecs[i].e_req));
      checkOutput($sformatf("v%0d_out_valid", i), 64'(out_valid), 64'(vecs[i].e_ov));
      if (vecs[i].e_ov) begin
        checkOutput($sformatf("v%0d_out_port", i), 64'(out_port), 64'(vecs[i].e_port));
        checkOutput($sformatf("v%0d_out_flit", i), 64'(out_flit), 64'(vecs[i].e_flit));
      end
      checkOutput($sformatf("v%0d_err_drop", i), 64'(err_drop), 64'd0);
      tick();
    end
    checkOutput("credit1_after_single", 64'(dut.credit[1]), 64'd3);
    checkOutput("credit0_after_packet", 64'(dut.credit[0]), 64'd1);

    // credit exhaustion: 6-flit packet, 4 credits, then one return per extra flit
    doReset();
    pkt[0] = H0; pkt[1] = B0; pkt[2] = B0; pkt[3] = B0; pkt[4] = B0; pkt[5] = T0;
    pkt_len = 6;
    pkt_idx = 0;
    grant_vector = 2'b01;
    runCycles(15, ov_cnt);
    checkOutput("credit_sent_before_stall", 64'(ov_cnt), 64'd4);
    checkOutput("credit_stall_request", 64'(request_vector), 64'd0);
    checkOutput("credit_stall_counter", 64'(dut.credit[0]), 64'd0);
    credit_in = 2'b01;
    runCycles(6, ov_cnt);
    checkOutput("credit_one_return", 64'(ov_cnt), 64'd1);
    checkOutput("credit_return_request", 64'(request_vector), 64'd0);
    credit_in = 2'b01;
    runCycles(6, ov_cnt);
    checkOutput("credit_tail_sent", 64'(ov_cnt), 64'd1);
    checkOutput("credit_tail_flit", 64'(last_flit), 64'(T0));
    checkOutput("credit_err_drop", 64'(err_drop), 64'd0);

    // FIFO full: no grant while 4 flits are pushed, a 5th must be refused
    doReset();
    pkt[0] = H0; pkt[1] = B0; pkt[2] = B0; pkt[3] = T0;
    pkt_len = 4;
    pkt_idx = 0;
    grant_vector = 2'b00;
    runCycles(4, ov_cnt);
    checkOutput("full_pushed", 64'(pkt_idx), 64'd4);
    checkOutput("full_in_ready", 64'(in_ready), 64'd0);
    in_valid = 1'b1;
    in_flit  = X0;
    tick();
    grant_vector = 2'b01;
    #1;
    checkOutput("full_pop_cycle_in_ready", 64'(in_ready), 64'd0);
    tick();
    in_valid = 1'b0;
    in_flit  = '0;
    #1;
    checkOutput("full_after_pop_in_ready", 64'(in_ready), 64'd1);
    pkt_len = 0;
    pkt_idx = 0;
    runCycles(8, ov_cnt);
    checkOutput("full_drained_count", 64'(ov_cnt), 64'd4);
    checkOutput("full_last_flit", 64'(last_flit), 64'(T0));
    checkOutput("full_no_fifth", 64'(err_drop), 64'd0);

    // orphan body flit while idle is dropped; a later single flit still goes through
    doReset();
    in_valid = 1'b1;
    in_flit  = B0;
    tick();
    in_valid = 1'b0;
    in_flit  = '0;
    grant_vector = 2'b11;
    #1;
    checkOutput("drop_no_request", 64'(request_vector), 64'd0);
    tick();
    checkOutput("drop_err_set", 64'(err_drop), 64'd1);
    checkOutput("drop_fifo_empty_ready", 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    in_flit  = S0;
    grant_vector = 2'b01;
    tick();
    in_valid = 1'b0;
    in_flit  = '0;
    #1;
    checkOutput("drop_next_idle_request", 64'(request_vector), 64'd0);
    tick();
    checkOutput("drop_next_request", 64'(request_vector), 64'd1);
    tick();
    checkOutput("drop_next_out_valid", 64'(out_valid), 64'd1);
    checkOutput("drop_next_out_flit", 64'(out_flit), 64'(S0));
    checkOutput("drop_next_out_port", 64'(out_port), 64'd1);
    checkOutput("drop_err_sticky", 64'(err_drop), 64'd1);

    // reset mid-packet after the head flit has left
    doReset();
    grant_vector = 2'b10;
    in_valid = 1'b1;
    in_flit  = H1;
    tick();
    in_flit  = B0;
    tick();
    in_flit  = T0;
    #1;
    checkOutput("rst_mid_request", 64'(request_vector), 64'd2);
    tick();
    in_valid = 1'b0;
    in_flit  = '0;
    grant_vector = 2'b00;
    #1;
    checkOutput("rst_mid_out_valid", 64'(out_valid), 64'd1);
    checkOutput("rst_mid_out_flit", 64'(out_flit), 64'(H1));
    RST = 1'b0;
    #1;
    checkOutput("rst_async_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_async_out_flit", 64'(out_flit), 64'd0);
    checkOutput("rst_async_out_port", 64'(out_port), 64'd0);
    checkOutput("rst_async_request", 64'(request_vector), 64'd0);
    checkOutput("rst_async_in_ready", 64'(in_ready), 64'd0);
    checkOutput("rst_async_credit1", 64'(dut.credit[1]), 64'd4);
    #1;
    RST = 1'b1;
    grant_vector = 2'b11;
    for (int c = 0; c < 3; c++) begin
      tick();
      checkOutput($sformatf("rst_after_request_%0d", c), 64'(request_vector), 64'd0);
      checkOutput($sformatf("rst_after_out_valid_%0d", c), 64'(out_valid), 64'd0);
      checkOutput($sformatf("rst_after_in_ready_%0d", c), 64'(in_ready), 64'd1);
    end
    credit_in = 2'b11;
    tick();
    credit_in = 2'b00;
    checkOutput("credit_saturate_0", 64'(dut.credit[0]), 64'd4);
    checkOutput("credit_saturate_1", 64'(dut.credit[1]), 64'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
